// File: rtl/cond_pkg.sv
// Shared condition-code encodings, flag bit positions and status type
// for the status register / condition evaluation slice.
package cond_pkg;

  typedef logic [3:0] status_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a 4-bit condition field against
// {N,Z,C,V} flags.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  status_t    flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_cond_unit.sv
// Status register, flag-hazard handling and saturating pass/fail counters.
// Build option: STATUS_FWD_EN forwards EXE flags instead of stalling.
module status_cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       statusIn,
  input  logic             sUpdate,
  input  logic             exeValid,
  input  logic             freeze,
  input  logic [3:0]       condCode,
  input  logic             idValid,
  input  logic             clearCounters,
  output logic             condPass,
  output logic             stall,
  output logic [3:0]       statusReg,
  output logic             carryOut,
  output logic [CNT_W-1:0] passCount,
  output logic [CNT_W-1:0] failCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  status_t status_q;
  status_t view;
  logic    hazard;
  logic    issue;
  logic    pass;

  assign hazard = idValid & exeValid & sUpdate
                & (condCode != COND_AL);

`ifdef STATUS_FWD_EN
  assign view  = hazard ? statusIn : status_q;
  assign stall = 1'b0;
`else
  assign view  = status_q;
  assign stall = hazard & ~rst;
`endif

  cond_eval u_cond_eval (
    .cond  (condCode),
    .flags (view),
    .pass  (pass)
  );

  assign condPass  = pass;
  assign statusReg = status_q;
  assign carryOut  = status_q[FLAG_C];
  assign issue     = idValid & ~stall & ~freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
    end else if (sUpdate & exeValid & ~freeze) begin
      status_q <= statusIn;
    end
  end

  // Clear has priority and is honoured even while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      passCount <= '0;
      failCount <= '0;
    end else if (clearCounters) begin
      passCount <= '0;
      failCount <= '0;
    end else if (issue) begin
      if (pass) begin
        if (passCount != CNT_MAX) passCount <= passCount + 1'b1;
      end else begin
        if (failCount != CNT_MAX) failCount <= failCount + 1'b1;
      end
    end
  end

endmodule
